// File: rtl/tape_rd_pkg.sv
// Shared types and constants for the tape read-port scheduler.
package tape_rd_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        GAPW  = 3'd0,
        OPEN  = 3'd1,
        SAMP  = 3'd2,
        MEM   = 3'd3,
        HOLD  = 3'd4,
        CLOSE = 3'd5
    } state_t;

    localparam logic [7:0] ERR_BYTE = 8'hFF;

endpackage

// File: rtl/tape_rd_rr.sv
// Round-robin grant pointer for the tape read scheduler: advances one requester per closed window.
module tape_rd_rr #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_c
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == IW'(N_REQ - 1)) ? '0 : ptr + IW'(1);
        end
    end

    assign grant_c = N_REQ'(1) << ptr;

endmodule

// File: rtl/tape_rd_scheduler.sv
// Time-slot scheduler sharing one byte read port among N_REQ strobe-protocol requesters.
// Optional memory-ack timeout enabled by defining TAPE_RD_TIMEOUT_EN.
module tape_rd_scheduler
    import tape_rd_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned AW      = 25,
    parameter int unsigned GAP     = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    output logic [N_REQ-1:0]    req_en,
    input  logic [N_REQ-1:0]    req_rd,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [7:0]          req_din,
    output logic                mem_rd,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    output logic                busy,
    output logic                rd_err
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GW = $clog2(GAP + 1);

    state_t                 state;
    logic [GW-1:0]          gap_cnt;
    logic [IW-1:0]          ptr;
    logic [N_REQ-1:0]       grant_c;
    logic                   advance_c;

    // Pointer moves on every window exit, served or empty.
    assign advance_c = (state == HOLD) || (state == CLOSE);

    tape_rd_rr #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance_c),
        .ptr     (ptr),
        .grant_c (grant_c)
    );

`ifdef TAPE_RD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] to_cnt;
    logic          rd_err_q;
    assign rd_err = rd_err_q;
`else
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GAPW;
            gap_cnt  <= GW'(GAP);
            req_en   <= '0;
            req_din  <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
`ifdef TAPE_RD_TIMEOUT_EN
            to_cnt   <= '0;
            rd_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                GAPW: begin
                    if (gap_cnt == GW'(1)) begin
                        req_en <= grant_c;
                        busy   <= 1'b1;
                        state  <= OPEN;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                OPEN: state <= SAMP;
                SAMP: begin
                    if (req_rd[ptr]) begin
                        mem_addr <= req_addr[int'(ptr)*AW +: AW];
                        mem_rd   <= 1'b1;
`ifdef TAPE_RD_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        state    <= MEM;
                    end else begin
                        state <= CLOSE;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        req_din <= mem_data;
                        mem_rd  <= 1'b0;
                        state   <= HOLD;
                    end
`ifdef TAPE_RD_TIMEOUT_EN
                    // Give up on a dead memory and hand back the error byte.
                    else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        req_din  <= ERR_BYTE;
                        mem_rd   <= 1'b0;
                        rd_err_q <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end
                HOLD, CLOSE: begin
                    req_en  <= '0;
                    busy    <= 1'b0;
                    gap_cnt <= GW'(GAP);
                    state   <= GAPW;
                end
                default: state <= GAPW;
            endcase
        end
    end

endmodule
